// File: rtl/judge_ctrl_if.sv
// Bundles the judge inputs (tick, arm, button, game-over) and the judge
// outputs (held code, strobe, statistics, combo) between judge_ctrl and
// its environment.
//   master : drives i_* and observes o_* (stimulus / upstream side)
//   slave  : the judge itself
interface judge_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             i_tick;
    logic             i_note_arm;
    logic             i_btn;
    logic             i_game_over;
    logic [1:0]       o_judge;
    logic             o_judge_pulse;
    logic [CNT_W-1:0] o_perfect_cnt;
    logic [CNT_W-1:0] o_normal_cnt;
    logic [CNT_W-1:0] o_miss_cnt;
    logic [CNT_W-1:0] o_combo;

    modport master (
        output i_tick, i_note_arm, i_btn, i_game_over,
        input  o_judge, o_judge_pulse, o_perfect_cnt, o_normal_cnt,
               o_miss_cnt, o_combo
    );

    modport slave (
        input  i_tick, i_note_arm, i_btn, i_game_over,
        output o_judge, o_judge_pulse, o_perfect_cnt, o_normal_cnt,
               o_miss_cnt, o_combo
    );
endinterface

// File: rtl/judge_ctrl.sv
// Timing judge for a rhythm game. Measures a button press against the
// ideal hit time of the armed note (in 1 ms ticks), classifies it as
// Perfect / Normal / Miss, holds the judge code for HOLD_MS ticks and keeps
// per-game statistics plus a combo counter.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : judge_ctrl_if.slave (tick, note arm, button, game over in;
//          judge code, judge strobe, perfect/normal/miss counts, combo out)
module judge_ctrl #(
    parameter int unsigned PERFECT_WIN = 30,
    parameter int unsigned NORMAL_WIN  = 100,
    parameter int unsigned HOLD_MS     = 300,
    parameter int unsigned CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    judge_ctrl_if.slave  bus
);
    localparam int unsigned WCNT_MAX = 2 * NORMAL_WIN;
    localparam int unsigned WCNT_W   = $clog2(WCNT_MAX + 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_MS + 1);

    localparam logic [1:0] CODE_MISS    = 2'b01;
    localparam logic [1:0] CODE_NORMAL  = 2'b10;
    localparam logic [1:0] CODE_PERFECT = 2'b11;

    typedef enum logic {
        IDLE,
        WINDOW
    } state_t;

    state_t             state;
    logic [WCNT_W-1:0]  wcnt;
    logic [HOLD_W-1:0]  hold;
    logic               s1, s2, s3;
    logic [1:0]         judge;
    logic               judge_pulse;
    logic [CNT_W-1:0]   perfect_cnt;
    logic [CNT_W-1:0]   normal_cnt;
    logic [CNT_W-1:0]   miss_cnt;
    logic [CNT_W-1:0]   combo;

    logic               press_c;
    logic [WCNT_W-1:0]  err_c;
    logic               hit_c;
    logic               miss_c;
    logic [1:0]         code_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Rising edge of the synchronised button
    assign press_c = s2 & ~s3;

    // Judgement decision for the current cycle; a press always beats the
    // timeout tick or a new arm, and nothing is judged while the game is over
    always_comb begin
        err_c  = '0;
        hit_c  = 1'b0;
        miss_c = 1'b0;
        code_c = CODE_MISS;
        if (wcnt >= WCNT_W'(NORMAL_WIN)) begin
            err_c = wcnt - WCNT_W'(NORMAL_WIN);
        end else begin
            err_c = WCNT_W'(NORMAL_WIN) - wcnt;
        end
        if (!bus.i_game_over && state == WINDOW) begin
            if (press_c) begin
                hit_c  = 1'b1;
                code_c = (err_c <= WCNT_W'(PERFECT_WIN)) ? CODE_PERFECT : CODE_NORMAL;
            end else if (bus.i_note_arm ||
                         (bus.i_tick && wcnt == WCNT_W'(WCNT_MAX))) begin
                miss_c = 1'b1;
                code_c = CODE_MISS;
            end
        end
    end

    // Window FSM, button synchroniser, hold timer and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            hold        <= '0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            judge       <= 2'b00;
            judge_pulse <= 1'b0;
            perfect_cnt <= '0;
            normal_cnt  <= '0;
            miss_cnt    <= '0;
            combo       <= '0;
        end else begin
            s1          <= bus.i_btn;
            s2          <= s1;
            s3          <= s2;
            judge_pulse <= 1'b0;

            if (bus.i_game_over) begin
                state <= IDLE;
                wcnt  <= '0;
                judge <= 2'b00;
                hold  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.i_note_arm) begin
                            state <= WINDOW;
                            wcnt  <= '0;
                        end
                    end
                    WINDOW: begin
                        if (hit_c) begin
                            // A same-cycle arm opens the next note's window
                            state <= bus.i_note_arm ? WINDOW : IDLE;
                            wcnt  <= '0;
                        end else if (bus.i_note_arm) begin
                            wcnt  <= '0;
                        end else if (bus.i_tick) begin
                            if (wcnt == WCNT_W'(WCNT_MAX)) begin
                                state <= IDLE;
                                wcnt  <= '0;
                            end else begin
                                wcnt  <= wcnt + WCNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end
                endcase

                if (hit_c || miss_c) begin
                    judge       <= code_c;
                    judge_pulse <= 1'b1;
                    hold        <= HOLD_W'(HOLD_MS);
                    if (miss_c) begin
                        miss_cnt <= sat_inc(miss_cnt);
                        combo    <= '0;
                    end else begin
                        combo <= sat_inc(combo);
                        if (code_c == CODE_PERFECT) begin
                            perfect_cnt <= sat_inc(perfect_cnt);
                        end else begin
                            normal_cnt  <= sat_inc(normal_cnt);
                        end
                    end
                end else if (bus.i_tick && hold != '0) begin
                    hold <= hold - HOLD_W'(1);
                    if (hold == HOLD_W'(1)) begin
                        judge <= 2'b00;
                    end
                end
            end
        end
    end

    assign bus.o_judge       = judge;
    assign bus.o_judge_pulse = judge_pulse;
    assign bus.o_perfect_cnt = perfect_cnt;
    assign bus.o_normal_cnt  = normal_cnt;
    assign bus.o_miss_cnt    = miss_cnt;
    assign bus.o_combo       = combo;
endmodule

// File: doc/judge_ctrl.md
Name: judge_ctrl

Overview:
- Timing judge directly upstream of the full-colour LED controller.
- Measures each button press against a note's ideal hit time, in 1 ms ticks.
- Classifies the press as Perfect, Normal or Miss.
- Drives a held 2-bit judge code (the LED controller's i_judge) and keeps per-game hit statistics and a combo counter.

Parameters:
- PERFECT_WIN, 30, half-width of the Perfect window in ticks (ms); must be < NORMAL_WIN.
- NORMAL_WIN, 100, half-width of the Normal window in ticks; the window spans 2*NORMAL_WIN+1 tick values.
- HOLD_MS, 300, number of ticks o_judge stays non-zero after a judgement.
- CNT_W, 8, width of the statistics and combo counters.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- i_tick, input, 1, 1-cycle pulse every 1 ms.
- i_note_arm, input, 1, 1-cycle pulse: a note is NORMAL_WIN ticks before its ideal hit time.
- i_btn, input, 1, debounced, asynchronous hit button (level, high = pressed).
- i_game_over, input, 1, level; high freezes judging.
- o_judge, output, 2, held judge code: 00 none, 01 Miss, 10 Normal, 11 Perfect.
- o_judge_pulse, output, 1, 1-cycle strobe when a new judgement is made.
- o_perfect_cnt, output, CNT_W, Perfect count.
- o_normal_cnt, output, CNT_W, Normal count.
- o_miss_cnt, output, CNT_W, Miss count.
- o_combo, output, CNT_W, current consecutive non-Miss count.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; window counter 0; hold timer 0; button sync flops 0.
- Button path:
  - i_btn passes through a 2-flop synchronizer, then a third flop.
  - press = s2 & ~s3.
  - If i_btn is high at edge N, press is true between edge N+1 and N+2, and the judgement registers at edge N+2.
- FSM IDLE:
  - i_note_arm -> WINDOW with wcnt=0.
  - A press in IDLE is ignored: no judgement, counters unchanged.
- FSM WINDOW:
  - wcnt increments on each i_tick.
  - On press: e = |wcnt - NORMAL_WIN|.
    - e <= PERFECT_WIN -> Perfect (11).
    - otherwise -> Normal (10).
    - Then go to IDLE.
  - If i_tick arrives while wcnt == 2*NORMAL_WIN and there is no press that cycle -> Miss (01), go to IDLE.
- Simultaneous events:
  - Press and timeout tick in the same cycle: the press wins.
  - i_note_arm in WINDOW with no press: the current note is judged Miss, and a new window starts with wcnt=0.
  - i_note_arm and press in the same cycle in WINDOW: the press judges the current note, then the new window starts (wcnt=0, state WINDOW).
  - i_note_arm and press in the same cycle in IDLE: the arm is accepted, the press is ignored.
- Judgement effects, all on the same edge:
  - o_judge is set to the code.
  - o_judge_pulse = 1 for one cycle.
  - The matching count is incremented.
  - o_combo: +1 on Perfect/Normal, cleared to 0 on Miss.
  - All counters saturate at 2^CNT_W-1.
  - The hold timer is loaded with HOLD_MS.
- Hold:
  - The hold timer decrements on i_tick while non-zero.
  - When it reaches 0, o_judge returns to 00.
  - A new judgement during hold overwrites the code and reloads the timer.
- i_game_over high:
  - FSM forced to IDLE, wcnt=0, o_judge forced 00, hold timer cleared.
  - Presses and arms are ignored.
  - Counters hold their values.
  - When i_game_over falls, the block resumes from IDLE.
  - Counters clear only on rst.
- Reset mid-window or mid-hold: immediate return to the reset state; no Miss is recorded.

Test Plan:
- Arm, then i_btn high 100 ticks later (wcnt=100) -> o_judge=11 at edge N+2, o_perfect_cnt=1, o_combo=1; o_judge=00 after 300 ticks.
- Arm, press at wcnt=40 (e=60) -> o_judge=10, o_normal_cnt=1. Repeat with press at wcnt=70 (e=30) -> 11; at wcnt=69 (e=31) -> 10.
- Arm, no press -> at the tick with wcnt=200, o_judge=01, o_miss_cnt=1, o_combo=0. Press and that tick in the same cycle -> 10 (e=100), no Miss.
- Arm at wcnt=150 with no press -> Miss recorded and a new window starts. Press 100 ticks later -> 11; o_combo=1.
- Hold 255 Perfects -> o_perfect_cnt and o_combo stay at 255 on the 256th.
- i_game_over high mid-window and mid-hold -> o_judge=00 next cycle, counts unchanged, presses ignored.
- Assert rst mid-window -> all outputs 0, no Miss recorded.
